mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
//  Serialises the two requests, returns read data to each stage and drives stall_pipl of control_unit.
//  The pipeline is frozen until every request active in the current cycle has completed.
//  Sits between the datapath and the external memory/bus interface.
// PARAMETERS
//  ADDR_W          32  address width
//  DATA_W          32  data width; mask width = DATA_W/8
//  TIMEOUT_CYCLES  64  cycles to wait for mem_ack_i before abort (ARB_TIMEOUT_EN only)
// PORTS
//  clk            in   1         single clock, rising edge
//  reset_n        in   1         asynchronous, active-low reset
//  if_req_i       in   1         fetch request, held stable while stalled
//  if_addr_i      in   ADDR_W    fetch address
//  if_rdata_o     out  DATA_W    fetched instruction (registered)
//  dm_req_i       in   1         data access request, held stable while stalled
//  dm_we_i        in   1         1 = store, 0 = load
//  dm_addr_i      in   ADDR_W    data address
//  dm_wdata_i     in   DATA_W    store data
//  dm_wmask_i     in   DATA_W/8  store byte enables
//  dm_rdata_o     out  DATA_W    load data (registered)
//  mem_req_o      out  1         memory request, held until ack
//  mem_we_o       out  1         memory write enable
//  mem_addr_o     out  ADDR_W    memory address
//  mem_wdata_o    out  DATA_W    memory write data
//  mem_wmask_o    out  DATA_W/8  memory byte enables
//  mem_rdata_i    in   DATA_W    memory read data, valid with ack
//  mem_ack_i      in   1         access complete; only meaningful while mem_req_o=1
//  stall_pipl_o   out  1         freeze pipeline (to control_unit.stall_pipl)
//  timeout_err_o  out  1         sticky timeout flag (tied 0 unless ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset values: state=IDLE; all other outputs 0, including mem_req_o, rdata regs, done flags and timeout_err_o.
//  States:
//  - IDLE: dm_req_i -> DM_ACC; else if_req_i -> IF_ACC; else stay.
//  - DM_ACC: on ack -> IF_ACC if if_req_i && !if_done, else DONE.
//  - IF_ACC: on ack -> DONE.
//  - DONE: -> IDLE unconditionally.
//  Priority: DM before IF (older instruction first); fixed, no fairness needed.
//  Driving memory:
//  - mem_req_o=1 in DM_ACC and IF_ACC only.
//  - mem_addr/we/wdata/wmask driven from the selected requester; all held constant until ack.
//  - mem_we_o=0 and mem_wmask_o=0 in IF_ACC.
//  On ack in DM_ACC:
//  - dm_rdata_o <= mem_rdata_i on loads; unchanged on stores.
//  - dm_done <= 1.
//  On ack in IF_ACC: if_rdata_o <= mem_rdata_i; if_done <= 1.
//  Stall:
//  - stall_pipl_o = (if_req_i & ~if_done) | (dm_req_i & ~dm_done); combinational.
//  - Forced 0 in DONE.
//  - Both done flags clear on the DONE->IDLE edge. The pipeline advances on that same edge.
//  Latency:
//  - Zero-wait memory: single request = 3 cycles (IDLE, ACC, DONE); both requests = 4 cycles.
//  - Each memory wait cycle adds 1.
//  - No request in IDLE: stall_pipl_o=0, no memory activity.
//  Ack arriving in IDLE or DONE is ignored.
//  Requests deasserted mid-access (e.g. flush): the current access still completes; its result is discarded.
//  Async reset mid-access: mem_req_o drops immediately; the memory side must drop the transaction.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//  - Counter loads 0 on ACC entry and increments while mem_req_o=1 && !mem_ack_i.
//  - At TIMEOUT_CYCLES-1 the access aborts: mem_req_o drops, rdata reg <= 0, done flag <= 1, timeout_err_o <= 1.
//  - timeout_err_o is sticky until reset; the FSM continues normally.
//  ARB_TIMEOUT_EN undefined: waits forever for ack; no counter logic; timeout_err_o tied 0.
// STRUCTURE
//  arb_pkg: arb_state_t enum {IDLE, DM_ACC, IF_ACC, DONE}, ADDR_W/DATA_W defaults.
//  Sub-module: arb_timeout_counter (clear, enable, expired), instantiated only under ARB_TIMEOUT_EN.
// TESTING
//  1. IF only: if_req=1, addr=0x100, ack on 1st ACC cycle, rdata=0x00500093 -> if_rdata_o=0x00500093; stall 1,1,0 over 3 cycles.
//  2. IF+load together: dm addr=0x2000 rdata=0xDEADBEEF, if rdata=0x13 -> mem_addr 0x2000 then 0x100; both rdata correct; stall low only in 4th cycle.
//  3. Store, 2 wait states: we=1, wdata=0xA5A5A5A5, mask=4'b0011 -> mem_* held stable 3 cycles; dm_rdata_o unchanged; total stall 4 cycles.
//  4. reset_n low while DM_ACC with mem_req_o=1 -> mem_req_o=0 immediately without clock; after release state=IDLE, stall=0.
//  5. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack never -> mem_req_o drops after 8 cycles; dm_rdata_o=0; timeout_err_o=1 sticky; next request served normally.
//  6. Stray ack in IDLE with no request -> no state change, rdata registers unchanged, stall_pipl_o=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and default widths for the IF/MEM unified-memory port arbiter.
package arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DM_ACC = 2'd1,
    IF_ACC = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  function automatic logic is_acc(input arb_state_t s);
    return (s == DM_ACC) || (s == IF_ACC);
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts cycles of an outstanding memory access; expired_o flags the last permitted wait cycle.
module arb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM stage requests onto one single-ported memory, DM first, and stalls the pipeline until both finish.
// Optional ARB_TIMEOUT_EN: aborts an access after TIMEOUT_CYCLES without ack and raises a sticky timeout_err_o.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  input  logic [DATA_W/8-1:0] dm_wmask_i,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i,
  output logic                stall_pipl_o,
  output logic                timeout_err_o
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;

  logic in_acc;
  logic acc_abort;
  logic acc_end;

  assign in_acc = is_acc(state_q);

`ifdef ARB_TIMEOUT_EN
  logic expired;
  logic err_q;

  arb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (~in_acc | mem_ack_i | expired),
    .enable_i (in_acc & ~mem_ack_i),
    .expired_o(expired)
  );

  assign acc_abort = in_acc & ~mem_ack_i & expired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (acc_abort) begin
      err_q <= 1'b1;
    end
  end

  assign timeout_err_o = err_q;
`else
  assign acc_abort     = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  assign acc_end = in_acc & (mem_ack_i | acc_abort);

  // Access fields are captured on ACC entry so a flush cannot disturb an in-flight access.
  always_comb begin
    state_d    = state_q;
    if_done_d  = if_done_q;
    dm_done_d  = dm_done_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;

    case (state_q)
      IDLE: begin
        if (dm_req_i) begin
          state_d = DM_ACC;
          addr_d  = dm_addr_i;
          we_d    = dm_we_i;
          wdata_d = dm_wdata_i;
          wmask_d = dm_wmask_i;
        end else if (if_req_i) begin
          state_d = IF_ACC;
          addr_d  = if_addr_i;
          we_d    = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
        end
      end
      DM_ACC: begin
        if (acc_end) begin
          dm_done_d = 1'b1;
          if (acc_abort) begin
            dm_rdata_d = '0;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
          if (if_req_i && !if_done_q) begin
            state_d = IF_ACC;
            addr_d  = if_addr_i;
            we_d    = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      IF_ACC: begin
        if (acc_end) begin
          if_done_d  = 1'b1;
          if_rdata_d = acc_abort ? '0 : mem_rdata_i;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        if_done_d = 1'b0;
        dm_done_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      state_q    <= state_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
    end
  end

  assign mem_req_o   = in_acc;
  assign mem_we_o    = in_acc & we_q;
  assign mem_addr_o  = in_acc ? addr_q : '0;
  assign mem_wdata_o = in_acc ? wdata_q : '0;
  assign mem_wmask_o = in_acc ? wmask_q : '0;

  assign if_rdata_o = if_rdata_q;
  assign dm_rdata_o = dm_rdata_q;

  assign stall_pipl_o = (state_q != DONE) &
                        ((if_req_i & ~if_done_q) | (dm_req_i & ~dm_done_q));

endmodule
